// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: FSM states, RISC-V funct3 codes and access sizing.
// Also defines the latched-request record that the FSM carries from accept to response.
package lsu_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE0, ISSUE1, CAPT, DONE} state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef struct packed {
        logic       write;
        logic [2:0] funct3;
        logic [2:0] off;
        logic       split;
    } req_t;

    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        return 4'd1 << funct3[1:0];
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Combinational load path: shifts the two-word window down by the byte offset,
// truncates to the access size and sign- or zero-extends per funct3.
module load_align_ext
    import lsu_pkg::*;
#(
    parameter int N = 64
) (
    input  logic [2*N-1:0] data,
    input  logic [2:0]     off,
    input  logic [2:0]     funct3,
    output logic [N-1:0]   rdata
);

    logic [N-1:0] shifted;

    always_comb begin
        shifted = N'(data >> {off, 3'b000});
        rdata   = '0;
        case (funct3)
            F3_B:    rdata = {{(N-8){shifted[7]}}, shifted[7:0]};
            F3_H:    rdata = {{(N-16){shifted[15]}}, shifted[15:0]};
            F3_W:    rdata = {{(N-32){shifted[31]}}, shifted[31:0]};
            F3_D:    rdata = shifted;
            F3_BU:   rdata = {{(N-8){1'b0}}, shifted[7:0]};
            F3_HU:   rdata = {{(N-16){1'b0}}, shifted[15:0]};
            F3_WU:   rdata = {{(N-32){1'b0}}, shifted[31:0]};
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/lsu_access_unit.sv
// Load/store unit between MEM stage and a 1-cycle byte-enabled RAM; splits word-crossing accesses.
// Latency 3/4 (load), 2/3 (store), 1 (fault); req_ready only in IDLE, one request in flight.
module lsu_access_unit
    import lsu_pkg::*;
#(
    parameter int N      = 64,
    parameter int ADDR_W = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [N-1:0]        req_addr,
    input  logic [2:0]          req_funct3,
    input  logic [N-1:0]        req_wdata,
    output logic                resp_valid,
    output logic [N-1:0]        resp_rdata,
    output logic                resp_fault,
    output logic [ADDR_W-1:0]   dm_wordAddr,
    output logic [N/8-1:0]      dm_byteena,
    output logic [N-1:0]        dm_writeData,
    output logic                dm_readEnable,
    output logic                dm_writeEnable,
    input  logic [N-1:0]        dm_readData
);

    localparam int BYTES = N / 8;

    state_t              state;
    req_t                req_q;
    logic [ADDR_W-1:0]   w0_q;
    logic [BYTES-1:0]    mask_hi_q;
    logic [N-1:0]        wdata_hi_q;
    logic [N-1:0]        lo_q;
    logic [N-1:0]        hi_q;
    logic [N-1:0]        load_rdata;

    logic [3:0]          size;
    logic [2:0]          off;
    logic [ADDR_W-1:0]   w0;
    logic                split;
    logic                fault;
    logic                accept;
    logic [2*BYTES-1:0]  mask16;
    logic [2*N-1:0]      wdata128;
    logic [N:0]          end_addr;

    always_comb begin
        size     = size_bytes(req_funct3);
        off      = req_addr[2:0];
        w0       = req_addr[ADDR_W+2:3];
        split    = ({1'b0, off} + size) > 4'd8;
        mask16   = (((2*BYTES)'(1) << size) - (2*BYTES)'(1)) << off;
        wdata128 = {{N{1'b0}}, req_wdata} << {off, 3'b000};
        // Last byte touched must stay inside the RAM's byte space.
        end_addr = {1'b0, req_addr} + (N+1)'(size) - (N+1)'(1);
        fault    = (|end_addr[N:ADDR_W+3]) ||
                   (req_write ? req_funct3[2] : (req_funct3 == 3'b111));
    end

    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    load_align_ext #(.N(N)) u_align (
        .data   ({hi_q, lo_q}),
        .off    (req_q.off),
        .funct3 (req_q.funct3),
        .rdata  (load_rdata)
    );

    // Data is only meaningful for a completed, non-faulting load.
    assign resp_rdata = (resp_valid && !resp_fault && !req_q.write) ? load_rdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            req_q          <= '0;
            w0_q           <= '0;
            mask_hi_q      <= '0;
            wdata_hi_q     <= '0;
            lo_q           <= '0;
            hi_q           <= '0;
            resp_valid     <= 1'b0;
            resp_fault     <= 1'b0;
            dm_wordAddr    <= '0;
            dm_byteena     <= '0;
            dm_writeData   <= '0;
            dm_readEnable  <= 1'b0;
            dm_writeEnable <= 1'b0;
        end else begin
            resp_valid     <= 1'b0;
            resp_fault     <= 1'b0;
            dm_wordAddr    <= '0;
            dm_byteena     <= '0;
            dm_writeData   <= '0;
            dm_readEnable  <= 1'b0;
            dm_writeEnable <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    req_q      <= '{write: req_write, funct3: req_funct3, off: off, split: split};
                    w0_q       <= w0;
                    mask_hi_q  <= mask16[2*BYTES-1:BYTES];
                    wdata_hi_q <= wdata128[2*N-1:N];
                    if (fault) begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                        resp_fault <= 1'b1;
                    end else begin
                        state          <= ISSUE0;
                        dm_wordAddr    <= w0;
                        dm_byteena     <= mask16[BYTES-1:0];
                        dm_writeData   <= req_write ? wdata128[N-1:0] : '0;
                        dm_readEnable  <= !req_write;
                        dm_writeEnable <= req_write;
                    end
                end
                ISSUE0: begin
                    if (req_q.split) begin
                        state          <= ISSUE1;
                        dm_wordAddr    <= w0_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        dm_byteena     <= mask_hi_q;
                        dm_writeData   <= req_q.write ? wdata_hi_q : '0;
                        dm_readEnable  <= !req_q.write;
                        dm_writeEnable <= req_q.write;
                    end else if (!req_q.write) begin
                        state <= CAPT;
                    end else begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                    end
                end
                ISSUE1: begin
                    if (!req_q.write) begin
                        lo_q  <= dm_readData;
                        state <= CAPT;
                    end else begin
                        state      <= DONE;
                        resp_valid <= 1'b1;
                    end
                end
                CAPT: begin
                    if (req_q.split) hi_q <= dm_readData;
                    else             lo_q <= dm_readData;
                    state      <= DONE;
                    resp_valid <= 1'b1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_access_unit.sv
// Bench for lsu_access_unit with a behavioural 1-cycle RAM and a byte-wise shadow memory model.
// Expected responses are queued at issue time and popped when resp_valid is seen.
module tb_lsu_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid, resp_fault;
    logic [63:0] resp_rdata;
    logic [11:0] dm_wordAddr;
    logic [7:0]  dm_byteena;
    logic [63:0] dm_writeData, dm_readData;
    logic        dm_readEnable, dm_writeEnable;

    lsu_access_unit #(.N(64), .ADDR_W(12)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .dm_wordAddr(dm_wordAddr), .dm_byteena(dm_byteena), .dm_writeData(dm_writeData),
        .dm_readEnable(dm_readEnable), .dm_writeEnable(dm_writeEnable), .dm_readData(dm_readData)
    );

    always #5 clk = ~clk;

    logic [63:0] ram [0:4095];
    logic [7:0]  shadow [0:32767];
    logic        poke_en = 1'b0;
    logic [11:0] poke_addr;
    logic [63:0] poke_data;

    always @(posedge clk) begin
        if (poke_en) ram[poke_addr] <= poke_data;
        else if (dm_writeEnable)
            for (int i = 0; i < 8; i++)
                if (dm_byteena[i]) ram[dm_wordAddr][8*i +: 8] <= dm_writeData[8*i +: 8];
        if (dm_readEnable) dm_readData <= ram[dm_wordAddr];
    end

    typedef struct {
        logic [63:0] rdata;
        logic        fault;
        int          lat;
    } exp_t;
    exp_t sbq[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic        r_got, r_fault;
    int          r_lat, ns;
    logic [63:0] r_rdata;
    logic [11:0] s_addr [2];
    logic [7:0]  s_be   [2];
    logic [63:0] s_wd   [2];
    logic        s_we   [2];

    task automatic poke(input logic [11:0] a, input logic [63:0] d);
        poke_addr = a; poke_data = d; poke_en = 1'b1;
        for (int i = 0; i < 8; i++) shadow[{a, 3'b000} + i] = d[8*i +: 8];
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    function automatic logic [63:0] model_load(input logic [14:0] a, input logic [2:0] f3);
        int sz = 1 << f3[1:0];
        logic [63:0] v = '0;
        for (int i = 0; i < sz; i++) v[8*i +: 8] = shadow[a + i];
        if (!f3[2] && sz < 8 && v[8*sz-1])
            for (int i = 8*sz; i < 64; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_store(input logic [14:0] a, input logic [2:0] f3, input logic [63:0] wd);
        for (int i = 0; i < (1 << f3[1:0]); i++) shadow[a + i] = wd[8*i +: 8];
    endtask

    function automatic int model_lat(input logic w, input logic [2:0] f3, input logic [14:0] a);
        logic sp = ((a % 8) + (1 << f3[1:0])) > 8;
        if (w) return sp ? 3 : 2;
        return sp ? 4 : 3;
    endfunction

    task automatic issue(input logic w, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input logic [63:0] er, input logic ef, input int el);
        exp_t e;
        e.rdata = er; e.fault = ef; e.lat = el;
        sbq.push_back(e);
        req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
        for (int g = 0; g < 20 && !req_ready; g++) begin @(posedge clk); #1; end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Records RAM strobes and the response; c is cycles since the accept edge.
    task automatic wait_resp;
        r_got = 1'b0; r_lat = 0; ns = 0; r_rdata = '0; r_fault = 1'b0;
        for (int c = 1; c <= 20 && !r_got; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (dm_readEnable || dm_writeEnable) begin
                if (ns < 2) begin
                    s_addr[ns] = dm_wordAddr; s_be[ns] = dm_byteena;
                    s_wd[ns] = dm_writeData; s_we[ns] = dm_writeEnable;
                end
                ns++;
            end
            if (resp_valid) begin
                r_got = 1'b1; r_lat = c; r_rdata = resp_rdata; r_fault = resp_fault;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_funct3 = '0; req_wdata = '0;
        repeat (2) @(posedge clk); #1;
        n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_in_reset: got %b want 0", req_ready); end
        n_checks++; if ({resp_valid, resp_fault, dm_readEnable, dm_writeEnable} !== 4'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b want 0000", {resp_valid, resp_fault, dm_readEnable, dm_writeEnable}); end
        n_checks++; if ({resp_rdata, dm_writeData, dm_byteena, dm_wordAddr} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h want 0", {resp_rdata, dm_writeData, dm_byteena, dm_wordAddr}); end
        reset = 1'b0; #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b want 1", req_ready); end
    endtask

    task automatic test_aligned_ld;
        issue(1'b0, 3'b011, 64'h10, '0, 64'h1122334455667788, 1'b0, 3);
        wait_resp;
        begin
            exp_t e = sbq.pop_front();
            n_checks++; if (!r_got || r_lat != e.lat) begin n_fail++; $display("FAIL ld_latency: got %0d (seen %b) want %0d", r_lat, r_got, e.lat); end
            n_checks++; if (r_rdata !== e.rdata) begin n_fail++; $display("FAIL ld_rdata: got %h want %h", r_rdata, e.rdata); end
            n_checks++; if (r_fault !== e.fault) begin n_fail++; $display("FAIL ld_fault: got %b want %b", r_fault, e.fault); end
        end
        n_checks++; if (ns != 1 || s_addr[0] !== 12'd2 || s_be[0] !== 8'hFF || s_we[0] !== 1'b0) begin
            n_fail++; $display("FAIL ld_ram_access: got n=%0d addr=%h be=%h we=%b want n=1 addr=002 be=ff we=0", ns, s_addr[0], s_be[0], s_we[0]); end
    endtask

    task automatic test_byte_ext;
        logic [2:0]  f3s [2] = '{3'b000, 3'b100};
        logic [63:0] exps [2] = '{64'hFFFF_FFFF_FFFF_FF80, 64'h0000_0000_0000_0080};
        poke(12'd2, 64'h1122334480667788);
        for (int k = 0; k < 2; k++) begin
            exp_t e;
            issue(1'b0, f3s[k], 64'h13, '0, exps[k], 1'b0, 3);
            wait_resp;
            e = sbq.pop_front();
            n_checks++; if (!r_got || r_rdata !== e.rdata) begin
                n_fail++; $display("FAIL byte_ext_f3_%0d: got %h (seen %b) want %h", f3s[k], r_rdata, r_got, e.rdata); end
        end
    endtask

    task automatic test_split;
        logic [2:0]  f3s [2] = '{3'b010, 3'b110};
        logic [63:0] exps [2] = '{64'hFFFF_FFFF_AABB_CCDD, 64'h0000_0000_AABB_CCDD};
        exp_t e;
        model_store(15'h0E, 3'b010, 64'hAABBCCDD);
        issue(1'b1, 3'b010, 64'h0E, 64'hAABBCCDD, '0, 1'b0, 3);
        wait_resp;
        e = sbq.pop_front();
        n_checks++; if (!r_got || r_lat != e.lat || r_rdata !== e.rdata) begin
            n_fail++; $display("FAIL sw_split_resp: got lat=%0d data=%h want lat=%0d data=%h", r_lat, r_rdata, e.lat, e.rdata); end
        n_checks++; if (ns != 2 || s_addr[0] !== 12'd1 || s_be[0] !== 8'hC0 || s_wd[0][63:48] !== 16'hCCDD || s_we[0] !== 1'b1) begin
            n_fail++; $display("FAIL sw_split_half0: got n=%0d addr=%h be=%h wd=%h want addr=001 be=c0 wd[63:48]=ccdd", ns, s_addr[0], s_be[0], s_wd[0]); end
        n_checks++; if (s_addr[1] !== 12'd2 || s_be[1] !== 8'h03 || s_wd[1][15:0] !== 16'hAABB || s_we[1] !== 1'b1) begin
            n_fail++; $display("FAIL sw_split_half1: got addr=%h be=%h wd=%h want addr=002 be=03 wd[15:0]=aabb", s_addr[1], s_be[1], s_wd[1]); end
        for (int k = 0; k < 2; k++) begin
            issue(1'b0, f3s[k], 64'h0E, '0, exps[k], 1'b0, 4);
            wait_resp;
            e = sbq.pop_front();
            n_checks++; if (!r_got || r_lat != e.lat || r_rdata !== e.rdata) begin
                n_fail++; $display("FAIL split_load_f3_%0d: got lat=%0d data=%h want lat=%0d data=%h", f3s[k], r_lat, r_rdata, e.lat, e.rdata); end
        end
    endtask

    task automatic test_range;
        logic        fw [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic [2:0]  ff [4] = '{3'b001, 3'b111, 3'b100, 3'b011};
        logic [63:0] fa [4] = '{64'h7FFF, 64'h20, 64'h20, 64'h8000};
        exp_t e;
        poke(12'hFFF, 64'hCAFE_0000_1234_5678);
        issue(1'b0, 3'b011, 64'h7FF8, '0, 64'hCAFE_0000_1234_5678, 1'b0, 3);
        wait_resp;
        e = sbq.pop_front();
        n_checks++; if (!r_got || r_fault !== e.fault || r_rdata !== e.rdata || s_addr[0] !== 12'hFFF) begin
            n_fail++; $display("FAIL top_word_ld: got fault=%b data=%h addr=%h want fault=0 data=%h addr=fff", r_fault, r_rdata, s_addr[0], e.rdata); end
        for (int k = 0; k < 4; k++) begin
            issue(fw[k], ff[k], fa[k], 64'hFFFF, '0, 1'b1, 1);
            wait_resp;
            e = sbq.pop_front();
            n_checks++; if (!r_got || r_fault !== e.fault || r_lat != e.lat || ns != 0 || r_rdata !== e.rdata) begin
                n_fail++; $display("FAIL fault_case_%0d: got fault=%b lat=%0d strobes=%0d data=%h want fault=1 lat=1 strobes=0 data=0", k, r_fault, r_lat, ns, r_rdata); end
        end
    endtask

    task automatic test_reset_mid;
        int pulses = 0;
        issue(1'b1, 3'b010, 64'h0E, 64'h11112222, '0, 1'b0, 3);
        @(posedge clk); #1;
        n_checks++; if (dm_writeEnable !== 1'b1 || dm_wordAddr !== 12'd2) begin
            n_fail++; $display("FAIL mid_reset_in_issue1: got we=%b addr=%h want we=1 addr=002", dm_writeEnable, dm_wordAddr); end
        reset = 1'b1; #1;
        n_checks++; if (dm_writeEnable !== 1'b0 || dm_byteena !== 8'h00 || req_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_drop: got we=%b be=%h ready=%b want 0 00 0", dm_writeEnable, dm_byteena, req_ready); end
        #1 reset = 1'b0; #1;
        n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready: got %b want 1", req_ready); end
        sbq.delete();
        repeat (4) begin @(posedge clk); #1; if (resp_valid) pulses++; end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL mid_reset_no_resp: got %0d pulses want 0", pulses); end
        poke(12'd1, 64'h0102030405060708);
        poke(12'd2, 64'h1122334455667788);
    endtask

    task automatic test_hold_valid;
        int accepts = 0, pulses = 0;
        logic ready_in_done = 1'b1;
        exp_t e;
        e.rdata = model_load(15'h10, 3'b011); e.fault = 1'b0; e.lat = 3;
        sbq.push_back(e);
        req_write = 1'b0; req_funct3 = 3'b011; req_addr = 64'h10; req_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (req_valid && req_ready) accepts++;
            @(posedge clk); #1;
            if (resp_valid) begin
                pulses++; r_rdata = resp_rdata; ready_in_done = req_ready; req_valid = 1'b0;
            end
        end
        e = sbq.pop_front();
        n_checks++; if (accepts != 1 || pulses != 1) begin
            n_fail++; $display("FAIL hold_valid_count: got accepts=%0d pulses=%0d want 1 1", accepts, pulses); end
        n_checks++; if (r_rdata !== e.rdata) begin n_fail++; $display("FAIL hold_valid_rdata: got %h want %h", r_rdata, e.rdata); end
        n_checks++; if (ready_in_done !== 1'b0) begin n_fail++; $display("FAIL ready_during_done: got %b want 0", ready_in_done); end
    endtask

    task automatic test_back_to_back;
        for (int k = 0; k < 40; k++) begin
            logic        w  = 1'($urandom % 2);
            logic [2:0]  f3 = w ? 3'($urandom % 4) : 3'($urandom % 7);
            logic [14:0] a  = 15'($urandom % 248);
            logic [63:0] wd = {$urandom, $urandom};
            logic [63:0] er = '0;
            exp_t e;
            if (w) model_store(a, f3, wd);
            else   er = model_load(a, f3);
            issue(w, f3, {49'b0, a}, wd, er, 1'b0, model_lat(w, f3, a));
            wait_resp;
            e = sbq.pop_front();
            n_checks++; if (!r_got || r_lat != e.lat || r_rdata !== e.rdata || r_fault !== e.fault) begin
                n_fail++; $display("FAIL rand_%0d w=%b f3=%0d a=%h: got lat=%0d data=%h fault=%b want lat=%0d data=%h fault=%b",
                                   k, w, f3, a, r_lat, r_rdata, r_fault, e.lat, e.rdata, e.fault); end
        end
    endtask

    initial begin
        test_reset;
        for (int i = 0; i < 36; i++) poke(12'(i), {$urandom, $urandom});
        poke(12'd2, 64'h1122334455667788);
        test_aligned_ld;
        test_byte_ext;
        test_split;
        test_range;
        test_reset_mid;
        test_hold_valid;
        test_back_to_back;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
